// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: one byte/half/word access per op over a valid/ready memory bus.
// Optional WAIT-state abort is enabled by defining YSYX_23060061_LSU_TIMEOUT_EN.
module ysyx_23060061_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [XLEN-1:0] mem_resp_data
);

  // state  | meaning
  // IDLE   | ready to accept an op
  // REQ    | memory request presented, waiting for mem_req_ready
  // WAIT   | waiting for read data / write ack
  // DONE   | result presented to writeback
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]      req_wmask_q, req_wmask_d;
  logic            req_wen_q, req_wen_d;

  logic            is_mem, f3_ok, misalign, timeout;
  logic [XLEN-1:0] st_wdata, shifted, load_val;
  logic [3:0]      st_wmask;

  assign is_mem   = in_is_load || in_is_store;
  assign misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                    ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

  always_comb begin
    f3_ok = 1'b0;
    if (in_is_store) f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    else             f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                             (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
  end

  // Replicate store data across lanes so the mask alone selects the bytes written.
  always_comb begin
    st_wdata = in_wdata;
    st_wmask = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_wmask = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_wmask = 4'b0011 << in_addr[1:0];
      end
      default: ;
    endcase
  end

  assign shifted = mem_resp_data >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

`ifdef YSYX_23060061_LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  assign wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + CW'(1) : '0;
  assign timeout    = (state_q == S_WAIT) && (wait_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    req_wen_d   = req_wen_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          funct3_d   = in_funct3;
          off_d      = in_addr[1:0];
          out_data_d = '0;
          out_err_d  = 1'b0;
          if (!is_mem) begin
            out_data_d = in_addr;
            state_d    = S_DONE;
          end else if (!f3_ok || misalign) begin
            out_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            req_addr_d  = {in_addr[XLEN-1:2], 2'b00};
            req_wen_d   = in_is_store;
            req_wdata_d = in_is_store ? st_wdata : '0;
            req_wmask_d = in_is_store ? st_wmask : 4'b0000;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          out_data_d = req_wen_q ? '0 : load_val;
          out_err_d  = 1'b0;
          state_d    = S_DONE;
        end else if (timeout) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      off_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      req_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      req_wen_q   <= req_wen_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign out_valid      = (state_q == S_DONE);
  assign out_data       = out_data_q;
  assign out_err        = out_err_q;
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = req_addr_q;
  assign mem_req_wen    = req_wen_q;
  assign mem_req_wdata  = req_wdata_q;
  assign mem_req_wmask  = req_wmask_q;
  assign mem_resp_ready = (state_q == S_WAIT);

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Self-checking bench for ysyx_23060061_lsu: vector table, hand sequences, random ops vs model.
// Timeout behaviour checked according to YSYX_23060061_LSU_TIMEOUT_EN.
module tb_ysyx_23060061_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060061_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
  );

  typedef struct {
    logic        done, saw_req, err, wen, req_unstable, out_unstable, inrdy_busy;
    logic [31:0] data, addr, wdata;
    logic [3:0]  wmask;
    int          lat, wait_cyc;
  } res_t;

  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    logic        exp_mem;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic [31:0] exp_addr, exp_wdat;
    logic [3:0]  exp_mask;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: derived from access size, byte offset and legality rules with plain arithmetic.
  function automatic void ref_op(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                 output logic mem, output logic [31:0] dat, output logic err,
                                 output logic [31:0] waddr, output logic [31:0] wdat,
                                 output logic [3:0] wmask);
    int     idx, size;
    bit     legal;
    longint v;
    idx = int'(a % 4);
    mem = 0; dat = 0; err = 0; waddr = a - idx; wdat = 0; wmask = 0;
    if (!ld && !st) begin
      dat = a;
      return;
    end
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : (f3 % 4 == 2) ? 4 : 0;
    legal = (size != 0) && (f3 < 4 || (ld && size < 4));
    if (!legal || (idx % size) != 0) begin
      err = 1;
      return;
    end
    mem = 1;
    if (st) begin
      for (int k = 0; k < 4; k++) begin
        wmask[k] = (k >= idx) && (k < idx + size);
        wdat[8*k +: 8] = wd[8*(k % size) +: 8];
      end
    end else begin
      v = longint'(rd) >> (8 * idx);
      if (size < 4) begin
        v = v % (longint'(1) << (8 * size));
        if (f3 < 4 && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
      end
      dat = v[31:0];
    end
  endfunction

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int req_stall, input int out_stall, input logic give_resp,
                       input int max_cyc, output res_t r);
    int rs, os;
    r  = '{default: '0};
    rs = req_stall;
    os = out_stall;
    @(negedge clk);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_addr = a; in_wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
    in_funct3 = 3'($urandom); in_is_load = 1'b0; in_is_store = 1'b0;
    for (int c = 1; c <= max_cyc && !r.done; c++) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
      if (in_ready) r.inrdy_busy = 1'b1;
      if (mem_req_valid) begin
        if (!r.saw_req) begin
          r.saw_req = 1'b1; r.addr = mem_req_addr; r.wdata = mem_req_wdata;
          r.wmask = mem_req_wmask; r.wen = mem_req_wen;
        end else if (r.addr !== mem_req_addr || r.wdata !== mem_req_wdata ||
                     r.wmask !== mem_req_wmask || r.wen !== mem_req_wen) begin
          r.req_unstable = 1'b1;
        end
        if (rs > 0) rs--;
        else mem_req_ready = 1'b1;
      end
      if (mem_resp_ready) begin
        r.wait_cyc++;
        if (give_resp) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = rd;
        end
      end
      if (out_valid) begin
        if (r.lat == 0) begin
          r.lat = c; r.data = out_data; r.err = out_err;
        end else if (out_data !== r.data || out_err !== r.err) begin
          r.out_unstable = 1'b1;
        end
        if (os > 0) os--;
        else begin
          out_ready = 1'b1;
          r.done    = 1'b1;
        end
      end
      @(negedge clk);
      if (!give_resp) mem_resp_data = $urandom;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic check_op(input string nm, input res_t r, input logic exp_mem,
                          input logic [31:0] exp_dat, input logic exp_err, input logic st,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdat,
                          input logic [3:0] exp_mask, input int exp_lat);
    chk({nm, " done"}, r.done, 1'b1);
    chk({nm, " data"}, r.data, exp_dat);
    chk({nm, " err"}, r.err, exp_err);
    chk({nm, " mem_req"}, r.saw_req, exp_mem);
    chk({nm, " latency"}, r.lat, exp_lat);
    chk({nm, " in_ready_busy"}, r.inrdy_busy, 1'b0);
    chk({nm, " in_ready_after"}, in_ready, 1'b1);
    if (exp_mem) begin
      chk({nm, " req_addr"}, r.addr, exp_addr);
      chk({nm, " req_wen"}, r.wen, st);
      chk({nm, " req_wmask"}, r.wmask, exp_mask);
      if (st) chk({nm, " req_wdata"}, r.wdata, exp_wdat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    res_t        r;
    logic        m_mem, m_err;
    logic [31:0] m_dat, m_addr, m_wdat;
    logic [3:0]  m_mask;

    vecs[0] = '{"lb_neg",   1, 0, 3'b000, 32'h80000003, 32'h0,        32'h80112233, 1, 32'hFFFFFF80, 0, 32'h80000000, 32'h0,        4'b0000};
    vecs[1] = '{"sh_hi",    0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h5A5A5A5A, 1, 32'h0,        0, 32'h80000000, 32'hABCDABCD, 4'b1100};
    vecs[2] = '{"lw_mis",   1, 0, 3'b010, 32'h80000001, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        4'b0000};
    vecs[3] = '{"lhu",      1, 0, 3'b101, 32'h10000002, 32'h0,        32'h8001FFFF, 1, 32'h00008001, 0, 32'h10000000, 32'h0,        4'b0000};
    vecs[4] = '{"sb_b3",    0, 1, 3'b000, 32'h00000003, 32'h000000A5, 32'h0,        1, 32'h0,        0, 32'h00000000, 32'hA5A5A5A5, 4'b1000};
    vecs[5] = '{"lh_sext",  1, 0, 3'b001, 32'h00000006, 32'h0,        32'h87654321, 1, 32'hFFFF8765, 0, 32'h00000004, 32'h0,        4'b0000};
    vecs[6] = '{"ld_f3_011",1, 0, 3'b011, 32'h00000000, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        4'b0000};
    vecs[7] = '{"st_f3_100",0, 1, 3'b100, 32'h00000100, 32'hCAFEF00D, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_addr = '0; in_wdata = '0; in_funct3 = '0; out_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_err", out_err, 1'b0);
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    chk("rst mem_req_addr", mem_req_addr, 32'h0);
    chk("rst mem_req_wmask", mem_req_wmask, 4'h0);
    chk("rst mem_req_wen", mem_req_wen, 1'b0);
    chk("rst mem_resp_ready", mem_resp_ready, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd, 0, 0, 1'b1, 50, r);
      check_op(vecs[i].name, r, vecs[i].exp_mem, vecs[i].exp_dat, vecs[i].exp_err, vecs[i].st,
               vecs[i].exp_addr, vecs[i].exp_wdat, vecs[i].exp_mask, vecs[i].exp_mem ? 3 : 1);
    end

    do_op(1'b0, 1'b0, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0, 0, 4, 1'b1, 50, r);
    check_op("pass_bp", r, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1);
    chk("pass_bp out_stable", r.out_unstable, 1'b0);

    do_op(1'b0, 1'b1, 3'b010, 32'h00000100, 32'hCAFEF00D, 32'h0, 3, 0, 1'b1, 50, r);
    check_op("sw_req_bp", r, 1'b1, 32'h0, 1'b0, 1'b1, 32'h00000100, 32'hCAFEF00D, 4'b1111, 6);
    chk("sw_req_bp req_stable", r.req_unstable, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int          ty, rq, os;
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      ty = $urandom_range(0, 2);
      ld = (ty == 1); st = (ty == 2);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rq = $urandom_range(0, 2); os = $urandom_range(0, 2);
      ref_op(ld, st, f3, a, wd, rd, m_mem, m_dat, m_err, m_addr, m_wdat, m_mask);
      do_op(ld, st, f3, a, wd, rd, rq, os, 1'b1, 50, r);
      check_op($sformatf("rand%0d", n), r, m_mem, m_dat, m_err, st, m_addr, m_wdat, m_mask,
               m_mem ? 3 + rq : 1);
    end

`ifdef YSYX_23060061_LSU_TIMEOUT_EN
    do_op(1'b1, 1'b0, 3'b010, 32'h80000008, 32'h0, 32'h0, 0, 0, 1'b0, 50, r);
    chk("timeout done", r.done, 1'b1);
    chk("timeout err", r.err, 1'b1);
    chk("timeout data", r.data, 32'h0);
    chk("timeout wait_cycles", r.wait_cyc, 4);
    chk("timeout latency", r.lat, 6);
`else
    do_op(1'b1, 1'b0, 3'b010, 32'h80000008, 32'h0, 32'h0, 0, 0, 1'b0, 100, r);
    chk("no_timeout done", r.done, 1'b0);
    chk("no_timeout still_waiting", mem_resp_ready, 1'b1);
    chk("no_timeout out_valid", out_valid, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h80000000;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0;
    chk("midrst req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("midrst in_wait", mem_resp_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst mem_req_valid", mem_req_valid, 1'b0);
    chk("midrst in_ready", in_ready, 1'b1);
    chk("midrst resp_ready", mem_resp_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stale_resp out_valid", out_valid, 1'b0);
      chk("stale_resp in_ready", in_ready, 1'b1);
    end
    mem_resp_valid = 1'b0;
    do_op(1'b1, 1'b0, 3'b010, 32'h80000004, 32'h0, 32'h0BADF00D, 0, 0, 1'b1, 50, r);
    check_op("post_rst_lw", r, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 32'h80000004, 32'h0, 4'h0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_lsu.md
Name: ysyx_23060061_lsu

Overview:
Load/store unit directly downstream of the execute ALU. It consumes the ALU result as the effective address, or as the pass-through value for non-memory ops, plus the rs2 store data and funct3. It performs one byte-, half- or word-sized memory access over a valid/ready request/response bus, then delivers the aligned, extended result to writeback over a valid/ready handshake. Only one transaction is in flight at a time.

Parameters:
XLEN, 32, datapath and address width; only 32 is supported.
TIMEOUT, 255, maximum WAIT-state cycles before abort; used only with YSYX_23060061_LSU_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream op valid
in_ready  output  1  LSU can accept an op
in_addr  input  XLEN  ALU result: address or pass-through value
in_wdata  input  XLEN  store data (rs2)
in_is_load  input  1  op is a load
in_is_store  input  1  op is a store; never asserted together with in_is_load
in_funct3  input  3  RV32I width/sign code
out_valid  output  1  result valid to writeback
out_ready  input  1  writeback accepts result
out_data  output  XLEN  load result, pass-through value, or 0 for stores and errors
out_err  output  1  misaligned, illegal funct3, or timeout
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  word-aligned address, {in_addr[31:2],2'b00}
mem_req_wen  output  1  1 = write
mem_req_wdata  output  XLEN  lane-replicated store data
mem_req_wmask  output  4  byte-enable mask
mem_resp_valid  input  1  response valid (read data or write ack)
mem_resp_ready  output  1  LSU accepts response
mem_resp_data  input  XLEN  read data, full word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset, asynchronous on rst_n low:
  - state goes to IDLE.
  - All registered outputs clear to 0: out_valid, out_data, out_err, mem_req_*.
  - in_ready = 1 because it is decoded from IDLE.
  - A reset mid-transaction drops the transaction silently. No response is awaited afterwards.
- in_ready = (state==IDLE). The op and all inputs are captured on in_valid&&in_ready.
- IDLE transitions on accept:
  - Non-memory op (neither load nor store): go to DONE, out_data=in_addr, out_err=0.
  - Memory op with illegal funct3 (011, 110, 111, or load/store-only codes mismatched; stores allow only 000/001/010): go to DONE, out_err=1, out_data=0, no memory request.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): same as illegal funct3 (DONE, out_err=1, out_data=0, no request).
  - Otherwise: go to REQ with mem_req_valid=1.
- REQ:
  - Request fields are held stable while mem_req_valid=1 && !mem_req_ready.
  - On mem_req_ready: mem_req_valid drops, go to WAIT.
- WAIT:
  - mem_resp_ready=1 in WAIT only. A response arriving in any other state is ignored.
  - On mem_resp_valid: capture the result, go to DONE.
- DONE:
  - out_valid=1; out_data/out_err are held stable until out_ready, then go to IDLE.
  - There is no IDLE bypass: the next op is accepted the cycle after the out handshake.
- Store formatting, with o = addr[1:0]:
  - SB: wdata = {4{in_wdata[7:0]}}, wmask = 4'b0001<<o.
  - SH: wdata = {2{in_wdata[15:0]}}, wmask = 4'b0011<<o.
  - SW: wdata = in_wdata, wmask = 4'b1111.
- Loads drive wmask = 0 and wen = 0.
- Load extraction: s = mem_resp_data >> (8*o).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: s.
- Store completion: the write ack (mem_resp_valid) yields out_data=0, out_err=0. mem_resp_data is ignored.
- Latency, with accept at cycle 0:
  - Non-memory and error ops: out_valid at cycle 1.
  - Memory ops with zero-wait memory: mem_req_valid at cycle 1; if ready, resp accepted at cycle 2; out_valid at cycle 3.

Optional Feature:
YSYX_23060061_LSU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without mem_resp_valid, go to DONE with out_err=1, out_data=0.
  - A response arriving in the same cycle as the timeout wins (normal completion).
- Undefined: no counter; WAIT waits indefinitely.

Test Plan:
- Load byte: LB (funct3=000), addr 0x80000003, resp 0x80112233 -> req addr 0x80000000, wen=0, wmask=0; out_data=0xFFFFFF80, err=0, out_valid exactly 3 cycles after accept.
- Store half: SH, addr 0x80000002, wdata 0x1234ABCD -> req addr 0x80000000, wdata 0xABCDABCD, wmask=4'b1100, wen=1; after ack, out_data=0, err=0.
- Misaligned word: LW at 0x80000001 -> mem_req_valid never asserts; out_valid next cycle with err=1, out_data=0.
- Pass-through and backpressure:
  - Non-memory op with in_addr=0xDEADBEEF and out_ready held low 4 cycles -> out_valid, out_data=0xDEADBEEF stable; in_ready=0 until the handshake.
  - Separately, mem_req_ready low 3 cycles -> request fields unchanged across those cycles.
- Reset mid-op: assert rst_n low in WAIT -> same-edge async clear: out_valid=0, mem_req_valid=0, in_ready=1. A stale mem_resp_valid after release is ignored, and a new LW at 0x80000004 completes normally.
- Timeout (macro defined, TIMEOUT=4): LW with no response -> out_valid with err=1 after 4 WAIT cycles. With the macro undefined, still waiting after 100 cycles.
